// File: rtl/mac_result_writer.sv
// Result writer for the 4-lane MAC array: buffers up to two result groups,
// saturates each lane to 16 bits and streams the words into the result SRAM.
module mac_result_writer #(
  parameter int FRAME_WORDS = 64,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              res_valid,
  input  logic [17:0]       mu1,
  input  logic [17:0]       mu2,
  input  logic [17:0]       mu3,
  input  logic [17:0]       mu4,
  output logic              res_ready,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              frame_done,
  output logic              overflow
);

  localparam int DATA_W = 18;
  localparam int OUT_W  = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

  state_t                  state_q, state_d;
  logic [4*DATA_W-1:0]     fifo_p0 [2];
  logic                    rd_ptr, wr_ptr, next_rd;
  logic [1:0]              count;
  logic                    push, drop, pop, issue;
  logic [1:0]              lane;
  logic [4*DATA_W-1:0]     group_in, head;
  logic [DATA_W-1:0]       lane_word;
  logic [ADDR_W-1:0]       wr_addr;

  function automatic logic [OUT_W-1:0] sat16(input logic [DATA_W-1:0] v);
    return (v > 18'd65535) ? 16'hFFFF : v[OUT_W-1:0];
  endfunction

  assign group_in  = {mu4, mu3, mu2, mu1};
  assign res_ready = (count < 2'd2) || ((count == 2'd2) && (state_q == WR3));
  assign push      = res_valid && res_ready && !clear;
  assign drop      = res_valid && !res_ready && !clear;
  assign pop       = (state_q == WR3);
  assign next_rd   = pop ? ~rd_ptr : rd_ptr;

  // The entry written next may be arriving on this very edge, so bypass it.
  assign head = (push && (wr_ptr == next_rd)) ? group_in : fifo_p0[next_rd];

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (count != 2'd0) state_d = WR0;
        WR0:     state_d = WR1;
        WR1:     state_d = WR2;
        WR2:     state_d = WR3;
        WR3:     state_d = ((count == 2'd2) || push) ? WR0 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered, so the lane to present is chosen from the next state.
  always_comb begin
    issue = 1'b1;
    lane  = 2'd0;
    case (state_d)
      WR0:     lane = 2'd0;
      WR1:     lane = 2'd1;
      WR2:     lane = 2'd2;
      WR3:     lane = 2'd3;
      default: issue = 1'b0;
    endcase
  end

  always_comb begin
    case (lane)
      2'd0:    lane_word = head[DATA_W-1:0];
      2'd1:    lane_word = head[2*DATA_W-1:DATA_W];
      2'd2:    lane_word = head[3*DATA_W-1:2*DATA_W];
      default: lane_word = head[4*DATA_W-1:3*DATA_W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_p0[wr_ptr] <= group_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      overflow   <= 1'b0;
      wr_addr    <= '0;
      ram_cen    <= 1'b1;
      ram_wen    <= 1'b1;
      ram_addr   <= '0;
      ram_din    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= !ram_cen && (ram_addr == LAST_ADDR);
      if (clear) begin
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= 2'd0;
        overflow <= 1'b0;
        wr_addr  <= '0;
        ram_addr <= '0;
        ram_cen  <= 1'b1;
        ram_wen  <= 1'b1;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        rd_ptr  <= next_rd;
        count   <= count + {1'b0, push} - {1'b0, pop};
        if (drop) overflow <= 1'b1;
        ram_cen <= !issue;
        ram_wen <= !issue;
        if (issue) begin
          ram_addr <= wr_addr;
          ram_din  <= sat16(lane_word);
          wr_addr  <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mac_result_writer.md
# mac_result_writer

Downstream stage of the 4-lane MAC array. It captures each group of four 18-bit accumulated results (MU1..MU4) on a one-cycle valid pulse and buffers up to two groups. It saturates each result to 16 bits and writes the four words on consecutive cycles into the single-port result SRAM (active-low controls). Sequential addresses wrap per frame, and the block flags frame completion and buffer overflow.

## Interface
- FRAME_WORDS, 64: words per frame. Must be a multiple of 4 and ≤ 2^ADDR_W.
- ADDR_W, 8: SRAM address width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush. Priority over res_valid.
- res_valid  in  1  one-cycle pulse; mu1..mu4 are final.
- mu1, mu2, mu3, mu4  in  18 each  unsigned MAC results.
- res_ready  out  1  buffer can accept a group this cycle.
- ram_cen  out  1  SRAM chip enable, active-low.
- ram_wen  out  1  SRAM write enable, active-low.
- ram_addr  out  ADDR_W  SRAM word address.
- ram_din  out  16  SRAM write data.
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- overflow  out  1  sticky; a group was dropped.

## Operation
- **Buffer:** 2-entry FIFO of 72-bit groups, with a count of 0..2.
- **res_ready (combinational):** asserted when count<2, or when count==2 and the writer is issuing lane 3 this cycle.
- **Accept:** res_valid && res_ready pushes {mu4,mu3,mu2,mu1}.
- **Drop:** res_valid && !res_ready drops the group, sets overflow and leaves the FIFO unchanged.
- **FSM states:**
  - IDLE: the writer is not issuing writes.
  - WR0..WR3: the writer issues lane k of the head entry.
- **FSM transitions:**
  - IDLE→WR0 when count>0, evaluated on registered state (a group accepted at edge N starts WR0 after edge N).
  - WRk→WR(k+1).
  - WR3: pop the head; go to WR0 if another entry remains (including one pushed the same edge), otherwise go to IDLE.
- **Saturation:** each lane writes mu>65535 ? 16'hFFFF : mu[15:0].
- **Lane order:** mu1 at the lowest address.
- **Address:** 0..FRAME_WORDS-1, incremented after each write.
  - After word FRAME_WORDS-1 the address wraps to 0 and frame_done pulses.
- **clear:**
  - Empties the FIFO, forces IDLE and sets the address to 0.
  - Clears overflow and drops any group in flight.
  - res_valid in the same cycle is ignored and does not set overflow.
- **Reset values:** ram_cen=1, ram_wen=1, ram_addr=0, ram_din=0, frame_done=0, overflow=0, FIFO empty, state IDLE. res_ready=1 after reset.
- **Reset mid-write:** outputs return immediately to the reset values. No further writes occur. Partial groups are lost.

## Timing
- All SRAM outputs are registered.
- **Write latency:** res_valid sampled at edge N with the writer idle. Lane 1 is presented (ram_cen=ram_wen=0, ram_addr, ram_din) in cycle N+1..N+2, i.e. after edge N+1.
- **Lanes 2..4:** on the following three cycles, with no gaps.
- **Back-to-back groups:** write with no idle cycle, giving sustained throughput of 1 group / 4 cycles.
- **Idle outputs:** ram_cen=ram_wen=1 whenever not writing. ram_din and ram_addr hold their last values.
- **frame_done:** high for exactly one cycle, the cycle after the write of address FRAME_WORDS-1 is presented.
- **overflow:** rises the cycle after the dropping edge and stays high until clear or rst.

## Test plan
- **Single group:** after reset, res_valid with mu=1,2,3,4. Expect writes of 1,2,3,4 to addr 0,1,2,3 on four consecutive cycles, starting two edges after the pulse. Then ram_cen returns high.
- **Saturation:** mu1=18'h3FFFF, mu2=65535, mu3=65536, mu4=0. Expect data FFFF, FFFF, FFFF, 0000.
- **Back-to-back:** three res_valid pulses 1 cycle apart. Expect the third accepted only on the lane-3 cycle; otherwise overflow=1 and exactly 8 or 12 writes as the spec dictates. Also check the 4-cycle-spaced stream: 12 contiguous writes, overflow=0.
- **Frame wrap:** FRAME_WORDS=8, three groups. Expect addresses 0..7,0..3, with frame_done pulsing once, one cycle after the addr-7 write.
- **Mid-write reset:** assert rst during WR1. Expect ram_cen=ram_wen=1 and ram_addr=0 immediately, and no further writes. A new group afterwards writes at addr 0.
- **clear:** clear with overflow=1 and FIFO full, plus simultaneous res_valid. Expect overflow=0, no writes, next group at addr 0.
